// File: rtl/core_pkg.sv
// Shared core definitions: address width, NOP encoding and fetch FSM states.
// Imported by the fetch interface and the instruction_fetch unit.
package core_pkg;

    localparam int XLEN = 64;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FETCH,
        WAIT_RSP,
        ISSUE,
        WAIT_PC,
        FAULT
    } if_state_t;

    // Clear the two low bits of a PC (word alignment).
    function automatic logic [XLEN-1:0] pc_word_align(
        input logic [XLEN-1:0] pc
    );
        return pc & ~{{(XLEN-2){1'b0}}, 2'b11};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch unit bus: instruction-memory request/response, decode handshake,
// execute PC feedback and the misaligned-PC fault flag.
interface instruction_fetch_if;
    import core_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            pc_update_valid;
    logic [XLEN-1:0] next_PC;
    logic            fetch_fault;

    // Fetch unit side
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output if_valid,
        output if_pc,
        output if_instr,
        input  if_ready,
        input  pc_update_valid,
        input  next_PC,
        output fetch_fault
    );

    // Environment side: memory, decode and execute
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  if_valid,
        input  if_pc,
        input  if_instr,
        output if_ready,
        output pc_update_valid,
        output next_PC,
        input  fetch_fault
    );

endinterface

// File: rtl/instruction_fetch.sv
// Sequential-core fetch unit: PC register, one imem read in flight, decode handoff.
// Define IF_MISALIGN_TRAP_EN to trap on misaligned next_PC instead of aligning it.
module instruction_fetch
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_fetch_if.master bus
);

    if_state_t       state;
    if_state_t       state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic [31:0]     instr;
    logic [31:0]     instr_nxt;

    logic            if_hs;
    logic            pc_capture;
    logic [XLEN-1:0] pc_captured;
    logic            pc_misaligned;

    assign if_hs      = (state == ISSUE) && bus.if_ready;
    assign pc_capture = bus.pc_update_valid && (if_hs || (state == WAIT_PC));

`ifdef IF_MISALIGN_TRAP_EN
    assign pc_captured   = bus.next_PC;
    assign pc_misaligned = |bus.next_PC[1:0];
`else
    assign pc_captured   = pc_word_align(bus.next_PC);
    assign pc_misaligned = 1'b0;
`endif

    // Next-state, PC and instruction register update
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instr;
        unique case (state)
            FETCH: begin
                if (bus.imem_req_ready) begin
                    state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (bus.imem_rsp_valid) begin
                    instr_nxt = bus.imem_rsp_data;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (if_hs) begin
                    state_nxt = WAIT_PC;
                end
            end
            WAIT_PC: begin
                state_nxt = WAIT_PC;
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
        // Execute feedback in ISSUE (with handshake) or WAIT_PC wins
        if (pc_capture) begin
            pc_nxt    = pc_captured;
            state_nxt = pc_misaligned ? FAULT : FETCH;
        end
    end

    // State, PC and instruction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= RESET_PC;
            instr <= NOP_INSTR;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            instr <= instr_nxt;
        end
    end

    // Request is held off while reset is asserted
    assign bus.imem_req_valid = rst_n && (state == FETCH);
    assign bus.imem_req_addr  = pc;
    assign bus.if_valid       = (state == ISSUE);
    assign bus.if_pc          = pc;
    assign bus.if_instr       = instr;

`ifdef IF_MISALIGN_TRAP_EN
    assign bus.fetch_fault = (state == FAULT);
`else
    assign bus.fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: zero-wait memory model,
// scoreboard of expected fetch PCs, directed handshake scenarios.
module tb_instruction_fetch;
    import core_pkg::*;

    localparam logic [XLEN-1:0] RST_PC = 64'h1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC(RST_PC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic            req_ready = 1'b0;
    logic            mem_rsp   = 1'b0;
    logic            stray_rsp = 1'b0;
    logic [31:0]     mem_data  = 32'h0;
    logic            if_ready  = 1'b0;
    logic            upd       = 1'b0;
    logic [XLEN-1:0] npc       = '0;

    assign bus.imem_req_ready  = req_ready;
    assign bus.imem_rsp_valid  = mem_rsp | stray_rsp;
    assign bus.imem_rsp_data   = stray_rsp ? 32'hDEAD_BEEF : mem_data;
    assign bus.if_ready        = if_ready;
    assign bus.pc_update_valid = upd;
    assign bus.next_PC         = npc;

    int checks    = 0;
    int errors    = 0;
    int req_count = 0;
    int base;

    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] sb_pc;
    logic            pend      = 1'b0;
    logic [XLEN-1:0] pend_addr = '0;

    function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
        if (a == RST_PC) return 32'h0050_0093;
        return {a[29:0], 2'b11} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait memory: respond in the cycle after the request is accepted
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_rsp  = pend;
            mem_data = pend ? mem_word(pend_addr) : 32'h0;
            pend     = 1'b0;
            @(negedge clk);
            if (bus.imem_req_valid === 1'b1 && req_ready) begin
                pend      = 1'b1;
                pend_addr = bus.imem_req_addr;
                req_count++;
            end
        end
    end

    // Scoreboard: every decode handshake pops the expected PC
    always @(negedge clk) begin
        if (rst_n && bus.if_valid === 1'b1 && if_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                sb_pc = exp_q.pop_front();
                chk("if_pc", bus.if_pc, sb_pc);
                chk("if_instr", 64'(bus.if_instr), 64'(mem_word(sb_pc)));
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("rst_if_valid", 64'(bus.if_valid), 64'd0);
        chk("rst_if_pc", bus.if_pc, RST_PC);
        chk("rst_if_instr", 64'(bus.if_instr), 64'(NOP_INSTR));
        chk("rst_fault", 64'(bus.fetch_fault), 64'd0);
        step();
        step();
        req_ready = 1'b1;
        rst_n     = 1'b1;
        exp_q.push_back(RST_PC);
        #1;
        chk("c1_req_valid", 64'(bus.imem_req_valid), 64'd1);
        chk("c1_req_addr", bus.imem_req_addr, RST_PC);
    endtask

    task automatic wait_issue(input int exp_cycles);
        int n = 0;
        while (bus.if_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("issue_latency", 64'(n), 64'(exp_cycles));
    endtask

    task automatic accept(input logic [XLEN-1:0] target, input bit same,
                          input logic [XLEN-1:0] exp_pc, input bit push);
        if_ready = 1'b1;
        if (same) begin
            upd = 1'b1;
            npc = target;
        end
        step();
        if_ready = 1'b0;
        upd      = 1'b0;
        if (!same) begin
            chk("wait_pc_no_req", 64'(bus.imem_req_valid), 64'd0);
            upd = 1'b1;
            npc = target;
            step();
            upd = 1'b0;
        end
        if (push) exp_q.push_back(exp_pc);
    endtask

    task automatic chk_fetch(input string tag, input logic [XLEN-1:0] a);
        chk({tag, "_req_valid"}, 64'(bus.imem_req_valid), 64'd1);
        chk({tag, "_req_addr"}, bus.imem_req_addr, a);
    endtask

    initial begin
        #2;
        apply_reset();
        wait_issue(2);

        // Branch with update in handshake cycle: 3-cycle loop
        accept(64'h1010, 1'b1, 64'h1010, 1'b1);
        chk_fetch("branch", 64'h1010);
        wait_issue(2);

        // Update one cycle after the handshake: 4-cycle loop
        accept(64'h1020, 1'b0, 64'h1020, 1'b1);
        chk_fetch("late_upd", 64'h1020);
        wait_issue(2);

        // Memory backpressure then decode backpressure
        req_ready = 1'b0;
        accept(64'h1030, 1'b1, 64'h1030, 1'b1);
        base = req_count;
        for (int i = 0; i < 3; i++) begin
            chk_fetch("req_stall", 64'h1030);
            step();
        end
        req_ready = 1'b1;
        wait_issue(2);
        for (int i = 0; i < 4; i++) begin
            chk("dec_stall_valid", 64'(bus.if_valid), 64'd1);
            chk("dec_stall_pc", bus.if_pc, 64'h1030);
            chk("dec_stall_instr", 64'(bus.if_instr), 64'(mem_word(64'h1030)));
            step();
        end
        chk("one_request", 64'(req_count - base), 64'd1);
        accept(64'h1040, 1'b1, 64'h1040, 1'b1);

        // Stray response in FETCH, stray update in WAIT_RSP
        req_ready = 1'b0;
        stray_rsp = 1'b1;
        step();
        stray_rsp = 1'b0;
        chk_fetch("stray_rsp", 64'h1040);
        chk("stray_rsp_if_valid", 64'(bus.if_valid), 64'd0);
        req_ready = 1'b1;
        step();
        chk("wait_rsp_no_req", 64'(bus.imem_req_valid), 64'd0);
        upd = 1'b1;
        npc = 64'h2000;
        step();
        upd = 1'b0;
        wait_issue(0);
        accept(64'h1050, 1'b1, 64'h1050, 1'b1);
        chk_fetch("after_stray", 64'h1050);
        wait_issue(2);

        // Misaligned next PC
`ifdef IF_MISALIGN_TRAP_EN
        accept(64'h1006, 1'b1, 64'h1006, 1'b0);
        chk("fault_set", 64'(bus.fetch_fault), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("fault_no_req", 64'(bus.imem_req_valid), 64'd0);
            chk("fault_no_issue", 64'(bus.if_valid), 64'd0);
            step();
        end
        chk("fault_sticky", 64'(bus.fetch_fault), 64'd1);
        apply_reset();
`else
        accept(64'h1006, 1'b1, 64'h1004, 1'b1);
        chk("no_fault", 64'(bus.fetch_fault), 64'd0);
        chk_fetch("aligned", 64'h1004);
        wait_issue(2);
        accept(64'h1008, 1'b1, 64'h1008, 1'b1);
        chk_fetch("seq", 64'h1008);
`endif

        // Async reset while waiting for the memory response
        step();
        chk("pre_rst_wait_rsp", 64'(bus.imem_req_valid), 64'd0);
        #2;
        apply_reset();
        wait_issue(2);
        accept(64'h1010, 1'b1, 64'h1010, 1'b1);
        chk_fetch("post_rst", 64'h1010);
        chk("sb_pending", 64'(exp_q.size()), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
